// File: rtl/display_scan_controller.sv
// display_scan_controller: multi-cycle double-dabble binary-to-BCD conversion
// driving a 4-digit multiplexed common-anode 7-segment display.
module display_scan_controller #(
  parameter int   W           = 8,
  parameter int   REFRESH_DIV = 50000,
  parameter logic BLANK_LZ    = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in,
  input  logic         load,
  output logic         busy,
  output logic         done,
  output logic [15:0]  digits,
  output logic [6:0]   seg,
  output logic [3:0]   an
);
  localparam int RW = $clog2(REFRESH_DIV);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state_q, state_d;
  logic [W-1:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d, bcd_adj, digits_q, digits_d;
  logic [W+15:0] sh;
  logic [3:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [RW-1:0] ref_q, ref_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] an_q, an_d, nib;
  logic [6:0] seg_q, seg_d;
  logic wrap, z3, z2, z1, blank;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: dec = 7'b1000000;
      4'd1: dec = 7'b1111001;
      4'd2: dec = 7'b0100100;
      4'd3: dec = 7'b0110000;
      4'd4: dec = 7'b0011001;
      4'd5: dec = 7'b0010010;
      4'd6: dec = 7'b0000010;
      4'd7: dec = 7'b1111000;
      4'd8: dec = 7'b0000000;
      4'd9: dec = 7'b0010000;
      default: dec = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    digits_d = digits_q;
    bcd_adj  = bcd_q;
    for (int i = 0; i < 4; i++)
      bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    sh = {bcd_adj, bin_q} << 1;
    case (state_q)
      IDLE: if (load) begin
        state_d = SHIFT;
        bin_d   = in;
        bcd_d   = '0;
        cnt_d   = 4'(W);
        busy_d  = 1'b1;
      end
      SHIFT: begin
        bcd_d = sh[W+15:W];
        bin_d = sh[W-1:0];
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = COMMIT;
      end
      COMMIT: begin
        digits_d = bcd_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // an/seg are registered from the next index and next digits so they switch together
  always_comb begin
    wrap  = ref_q == RW'(REFRESH_DIV - 1);
    ref_d = wrap ? '0 : ref_q + RW'(1);
    idx_d = wrap ? idx_q + 2'd1 : idx_q;
    an_d  = ~(4'b0001 << idx_d);
    nib   = digits_d[4*idx_d +: 4];
    z3    = digits_d[15:12] == 4'd0;
    z2    = z3 && digits_d[11:8] == 4'd0;
    z1    = z2 && digits_d[7:4] == 4'd0;
    blank = BLANK_LZ && (idx_d == 2'd3 ? z3 : idx_d == 2'd2 ? z2 : idx_d == 2'd1 && z1);
    seg_d = blank ? 7'b1111111 : dec(nib);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      digits_q <= '0;
      ref_q    <= '0;
      idx_q    <= '0;
      an_q     <= 4'b1110;
      seg_q    <= 7'b1000000;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      digits_q <= digits_d;
      ref_q    <= ref_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end

  assign busy   = busy_q;
  assign done   = done_q;
  assign digits = digits_q;
  assign seg    = seg_q;
  assign an     = an_q;
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: randomized conversions on three configurations,
// checked against a decimal-arithmetic model of digits, timing and scan output.
module tb_display_scan_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] a_in = '0, b_in = '0;
  logic [12:0] c_in = '0;
  logic a_ld = 1'b0, b_ld = 1'b0, c_ld = 1'b0;
  logic a_busy, b_busy, c_busy, a_done, b_done, c_done;
  logic [15:0] a_dig, b_dig, c_dig;
  logic [6:0] a_seg, b_seg, c_seg;
  logic [3:0] a_an, b_an, c_an;
  int n_tests = 0, n_fail = 0, tick = 0;
  int exp_v [3] = '{0, 0, 0};
  localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  always #5 clk = ~clk;

  display_scan_controller #(.W(8), .REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in(a_in), .load(a_ld), .busy(a_busy), .done(a_done),
    .digits(a_dig), .seg(a_seg), .an(a_an));
  display_scan_controller #(.W(8), .REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in(b_in), .load(b_ld), .busy(b_busy), .done(b_done),
    .digits(b_dig), .seg(b_seg), .an(b_an));
  display_scan_controller #(.W(13), .REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_c (
    .clk(clk), .rst(rst), .in(c_in), .load(c_ld), .busy(c_busy), .done(c_done),
    .digits(c_dig), .seg(c_seg), .an(c_an));

  always @(posedge clk or posedge rst)
    if (rst) tick <= 0;
    else tick <= tick + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd(input int v);
    return 16'(((v / 1000) % 10) << 12 | ((v / 100) % 10) << 8 | ((v / 10) % 10) << 4 | (v % 10));
  endfunction

  function automatic logic [6:0] seg_exp(input int v, input int idx, input logic blank);
    int p = idx == 0 ? 1 : idx == 1 ? 10 : idx == 2 ? 100 : 1000;
    if (blank && idx > 0 && v < p) return 7'b1111111;
    return SEG[(v / p) % 10];
  endfunction

  function automatic logic [1:0] bd(input int sel);
    return sel == 0 ? {a_busy, a_done} : sel == 1 ? {b_busy, b_done} : {c_busy, c_done};
  endfunction

  task automatic check_all();
    int idx = (tick / 4) % 4;
    logic [3:0] an_e = ~(4'b0001 << idx);
    check("an_a", a_an, an_e);
    check("an_b", b_an, an_e);
    check("an_c", c_an, an_e);
    check("seg_a", a_seg, seg_exp(exp_v[0], idx, 1'b1));
    check("seg_b", b_seg, seg_exp(exp_v[1], idx, 1'b0));
    check("seg_c", c_seg, seg_exp(exp_v[2], idx, 1'b1));
    check("digits_a", a_dig, bcd(exp_v[0]));
    check("digits_b", b_dig, bcd(exp_v[1]));
    check("digits_c", c_dig, bcd(exp_v[2]));
  endtask

  task automatic drive(input int sel, input int v, input logic ld);
    case (sel)
      0: begin a_in = 8'(v); a_ld = ld; end
      1: begin b_in = 8'(v); b_ld = ld; end
      default: begin c_in = 13'(v); c_ld = ld; end
    endcase
  endtask

  // load v; optionally a second load (v2) at step ign_k that must be ignored
  task automatic convert(input int sel, input int v, input int ign_k, input int v2);
    int w = sel == 2 ? 13 : 8;
    logic [1:0] s;
    drive(sel, v, 1'b1);
    for (int k = 0; k <= w + 3; k++) begin
      @(negedge clk);
      if (k == w + 1) exp_v[sel] = v;
      check_all();
      s = bd(sel);
      check("busy", s[1], k <= w);
      check("done", s[0], k == w + 1);
      drive(sel, k == ign_k ? v2 : int'($urandom), k == ign_k);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all();
    check("rst_busy", {a_busy, b_busy, c_busy}, 0);
    check("rst_done", {a_done, b_done, c_done}, 0);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check_all();
      check("idle_bd", {a_busy, a_done, b_busy, b_done, c_busy, c_done}, 0);
    end
    convert(0, 255, -1, 0);
    convert(0, 7, 2, 200);
    convert(1, 5, -1, 0);
    convert(2, 8191, -1, 0);
    convert(0, 0, -1, 0);
    convert(2, 1000, 5, 17);
    convert(2, 9, -1, 0);
    convert(1, 0, -1, 0);
    repeat (12) begin
      convert(0, int'($urandom_range(0, 255)), $urandom_range(0, 1) ? int'($urandom_range(1, 7)) : -1,
              int'($urandom_range(0, 255)));
      convert(1, int'($urandom_range(0, 255)), -1, 0);
      convert(2, int'($urandom_range(0, 8191)), $urandom_range(0, 1) ? int'($urandom_range(1, 12)) : -1,
              int'($urandom_range(0, 8191)));
    end
    drive(0, 123, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(0, 123, 1'b0);
    end
    rst = 1'b1;
    #1;
    check("abort_busy", a_busy, 0);
    check("abort_digits", a_dig, 0);
    exp_v = '{0, 0, 0};
    repeat (2) begin
      @(negedge clk);
      check_all();
      check("abort_done", a_done, 0);
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      check_all();
      check("post_rst_done", {a_busy, a_done}, 0);
    end
    convert(0, 42, -1, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
